// File: rtl/queue_v2_pkg.sv
// queue_v2_pkg: shared helpers for the queue_v2 circular buffer.
//   ptr_w(depth)      : index width, $clog2(depth) (min 1)
//   cnt_w(depth)      : occupancy width, $clog2(depth+1)
//   ptr_inc(ptr,depth): wrap-around increment for any depth (not just 2^n)
package queue_v2_pkg;

  function automatic int ptr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [31:0] ptr_inc(logic [31:0] ptr, int depth);
    return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/queue_v2_if.sv
// queue_v2_if: request/response bundle of queue_v2.
//   master: requester side (drives flush/push/push_data/pop)
//   slave : queue side (drives pop_data/pop_resp/push_resp/push_ready,
//           full/empty/almost_full/almost_empty/count)
interface queue_v2_if import queue_v2_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) ();
  localparam int CNT_W = cnt_w(DEPTH);

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_resp;
  logic             push_resp;
  logic             push_ready;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, push, push_data, pop,
    input  pop_data, pop_resp, push_resp, push_ready,
           full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  flush, push, push_data, pop,
    output pop_data, pop_resp, push_resp, push_ready,
           full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/queue_v2_ptr.sv
// queue_ptr: wrapping index register for queue_v2 (used for head and tail).
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   en_i       : advance by one, wrapping DEPTH-1 -> 0
//   ptr_o      : current index
module queue_ptr import queue_v2_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)     ptr_d = '0;
    else if (en_i) ptr_d = PTR_W'(ptr_inc(32'(ptr_q), DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/queue_v2.sv
// queue_v2: parameterised circular queue, any DEPTH >= 2.
//   clk0, rst0 : clock, async active-low reset
//   q (slave)  : push/pop handshake, flush, occupancy and flags
// Pop is zero-latency (pop_data = head entry in the same cycle), push_resp
// is the registered acceptance of the previous cycle, flags derive from the
// registered count only. Optional macro QUEUE_V2_BYPASS_EN forwards
// push_data straight to pop_data on a push+pop to an empty queue.
module queue_v2 import queue_v2_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic       clk0,
  input  logic       rst0,
  queue_v2_if.slave  q
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_resp_q, push_resp_d;
  logic             is_empty, is_full;
  logic             pop_acc, push_acc, byp, wr_en, rd_en;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
`ifdef QUEUE_V2_BYPASS_EN
    byp = is_empty && q.push && q.pop && !q.flush;
`else
    byp = 1'b0;
`endif
    pop_acc  = q.pop && !is_empty;
    push_acc = q.push && (!is_full || pop_acc);
    // flush squashes all state changes; a bypassed entry never touches storage
    wr_en    = push_acc && !q.flush && !byp;
    rd_en    = pop_acc && !q.flush;
  end

  always_comb begin
    count_d = count_q;
    if (q.flush)              count_d = '0;
    else if (wr_en && !rd_en) count_d = count_q + CNT_W'(1);
    else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
    push_resp_d = push_acc && !q.flush;
  end

  always_ff @(posedge clk0 or negedge rst0) begin
    if (!rst0) begin
      count_q     <= '0;
      push_resp_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      push_resp_q <= push_resp_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk0) begin
    if (wr_en) mem_q[tail] <= q.push_data;
  end

  queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .clk(clk0), .rst_n(rst0), .clr_i(q.flush), .en_i(rd_en), .ptr_o(head)
  );

  queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .clk(clk0), .rst_n(rst0), .clr_i(q.flush), .en_i(wr_en), .ptr_o(tail)
  );

  assign q.pop_data     = byp ? q.push_data : (pop_acc ? mem_q[head] : 'x);
  assign q.pop_resp     = pop_acc || byp;
  assign q.push_ready   = !is_full || pop_acc;
  assign q.push_resp    = push_resp_q;
  assign q.full         = is_full;
  assign q.empty        = is_empty;
  assign q.almost_full  = int'(count_q) >= AF_THRESH;
  assign q.almost_empty = int'(count_q) <= AE_THRESH;
  assign q.count        = count_q;
endmodule

// File: tb/tb_queue_v2.sv
// tb_queue_v2: three queue_v2 instances (DEPTH 8, 5, 4) driven by directed
// vectors; a queue-based reference model is checked every cycle, plus
// hand-computed literal expectations.
module tb_queue_v2;
  localparam int N = 3;
  localparam int DEP [N] = '{8, 5, 4};

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  always #5 clk0 = ~clk0;

  logic [N-1:0]       push_v = '0, pop_v = '0, flush_v = '0;
  logic [N-1:0][31:0] pd_v = '0;

  logic [N-1:0][31:0] o_pdata, o_cnt;
  logic [N-1:0]       o_presp, o_wresp, o_rdy, o_full, o_empty, o_af, o_ae;

  for (genvar g = 0; g < N; g++) begin : g_dut
    queue_v2_if #(.WIDTH(32), .DEPTH(DEP[g])) qi ();
    assign qi.flush     = flush_v[g];
    assign qi.push      = push_v[g];
    assign qi.push_data = pd_v[g];
    assign qi.pop       = pop_v[g];
    queue_v2 #(.WIDTH(32), .DEPTH(DEP[g])) dut (
      .clk0(clk0), .rst0(rst0), .q(qi.slave)
    );
    assign o_pdata[g] = qi.pop_data;
    assign o_cnt[g]   = 32'(qi.count);
    assign o_presp[g] = qi.pop_resp;
    assign o_wresp[g] = qi.push_resp;
    assign o_rdy[g]   = qi.push_ready;
    assign o_full[g]  = qi.full;
    assign o_empty[g] = qi.empty;
    assign o_af[g]    = qi.almost_full;
    assign o_ae[g]    = qi.almost_empty;
  end

  int n_tot = 0, n_pass = 0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s[d%0d] got=%h want=%h t=%0t", nm, k, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model: one plain queue per instance
  logic [31:0]  mq [N][$];
  logic [N-1:0] m_wresp = '0;

  function automatic bit m_byp(int k);
`ifdef QUEUE_V2_BYPASS_EN
    return mq[k].size() == 0 && push_v[k] && pop_v[k] && !flush_v[k];
`else
    return 1'b0;
`endif
  endfunction
  function automatic bit m_pacc(int k);
    return pop_v[k] && mq[k].size() != 0;
  endfunction
  function automatic bit m_wacc(int k);
    return push_v[k] && (mq[k].size() < DEP[k] || m_pacc(k));
  endfunction

  always @(posedge clk0 or negedge rst0) begin
    for (int k = 0; k < N; k++) begin
      if (!rst0) begin
        mq[k].delete();
        m_wresp[k] <= 1'b0;
      end else if (flush_v[k]) begin
        mq[k].delete();
        m_wresp[k] <= 1'b0;
      end else begin : upd
        automatic bit pa = m_pacc(k);
        automatic bit wa = m_wacc(k);
        automatic bit bp = m_byp(k);
        m_wresp[k] <= wa;
        if (!bp) begin
          if (pa) void'(mq[k].pop_front());
          if (wa) mq[k].push_back(pd_v[k]);
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  bit chk_en = 1'b0;
  always @(negedge clk0) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin : cmp
        automatic int n  = mq[k].size();
        automatic bit pr = m_pacc(k) || m_byp(k);
        chk("cmp_count", k, o_cnt[k], 32'(n));
        chk("cmp_empty", k, 32'(o_empty[k]), 32'(n == 0));
        chk("cmp_full", k, 32'(o_full[k]), 32'(n == DEP[k]));
        chk("cmp_af", k, 32'(o_af[k]), 32'(n >= DEP[k] - 1));
        chk("cmp_ae", k, 32'(o_ae[k]), 32'(n <= 1));
        chk("cmp_push_resp", k, 32'(o_wresp[k]), 32'(m_wresp[k]));
        chk("cmp_pop_resp", k, 32'(o_presp[k]), 32'(pr));
        chk("cmp_push_ready", k, 32'(o_rdy[k]), 32'(n < DEP[k] || m_pacc(k)));
        if (pr) chk("cmp_pop_data", k, o_pdata[k], m_byp(k) ? pd_v[k] : mq[k][0]);
      end
    end
  end

  // ---------------- directed stimulus
  task automatic nxt();
    @(posedge clk0); #1;
    push_v = '0; pop_v = '0; flush_v = '0;
  endtask
  task automatic smp();
    @(negedge clk0);
  endtask
  task automatic drv(int k, bit pu, bit po, bit fl, logic [31:0] d);
    push_v[k] = pu; pop_v[k] = po; flush_v[k] = fl; pd_v[k] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst0 = 1'b0;
    #1 chk_en = 1'b1;
    // reset state, DEPTH=8
    nxt(); smp();
    chk("lit_rst_empty", 0, 32'(o_empty[0]), 1);
    chk("lit_rst_full", 0, 32'(o_full[0]), 0);
    chk("lit_rst_count", 0, o_cnt[0], 0);
    chk("lit_rst_ae", 0, 32'(o_ae[0]), 1);
    chk("lit_rst_wresp", 0, 32'(o_wresp[0]), 0);
    nxt(); rst0 = 1'b1; smp();
    nxt(); drv(0, 0, 1, 0, 0); smp();
    chk("lit_pop_empty", 0, 32'(o_presp[0]), 0);

    // DEPTH=5 fill
    for (int i = 0; i < 5; i++) begin
      nxt(); drv(1, 1, 0, 0, 32'hA0 + 32'(i)); smp();
      chk("lit_fill_cnt", 1, o_cnt[1], 32'(i));
      chk("lit_fill_wresp", 1, 32'(o_wresp[1]), 32'(i > 0));
      chk("lit_fill_af", 1, 32'(o_af[1]), 32'(i >= 4));
    end
    nxt(); drv(1, 1, 0, 0, 32'hA5); smp();
    chk("lit_sixth_rdy", 1, 32'(o_rdy[1]), 0);
    chk("lit_full", 1, 32'(o_full[1]), 1);
    chk("lit_full_cnt", 1, o_cnt[1], 5);
    nxt(); smp();
    chk("lit_sixth_drop", 1, o_cnt[1], 5);
    chk("lit_sixth_nowresp", 1, 32'(o_wresp[1]), 0);
    // drain
    for (int i = 0; i < 5; i++) begin
      nxt(); drv(1, 0, 1, 0, 0); smp();
      chk("lit_drain_data", 1, o_pdata[1], 32'hA0 + 32'(i));
      chk("lit_drain_resp", 1, 32'(o_presp[1]), 1);
    end
    nxt(); drv(1, 1, 0, 0, 32'hB0); smp();
    nxt(); drv(1, 0, 1, 0, 0); smp();
    chk("lit_wrap_data", 1, o_pdata[1], 32'hB0);

    // DEPTH=4 full with push+pop
    for (int i = 1; i <= 4; i++) begin
      nxt(); drv(2, 1, 0, 0, 32'(i)); smp();
    end
    nxt(); drv(2, 1, 1, 0, 5); smp();
    chk("lit_fpp_data", 2, o_pdata[2], 1);
    chk("lit_fpp_resp", 2, 32'(o_presp[2]), 1);
    chk("lit_fpp_rdy", 2, 32'(o_rdy[2]), 1);
    nxt(); smp();
    chk("lit_fpp_cnt", 2, o_cnt[2], 4);
    for (int i = 2; i <= 5; i++) begin
      nxt(); drv(2, 0, 1, 0, 0); smp();
      chk("lit_fpp_drain", 2, o_pdata[2], 32'(i));
    end

    // flush with 3 entries and a concurrent push (DEPTH=8)
    for (int i = 1; i <= 3; i++) begin
      nxt(); drv(0, 1, 0, 0, 32'h30 + 32'(i)); smp();
    end
    nxt(); drv(0, 1, 0, 1, 32'h77); smp();
    nxt(); smp();
    chk("lit_flush_cnt", 0, o_cnt[0], 0);
    chk("lit_flush_empty", 0, 32'(o_empty[0]), 1);
    chk("lit_flush_wresp", 0, 32'(o_wresp[0]), 0);
    nxt(); drv(0, 0, 1, 0, 0); smp();
    chk("lit_flush_pop", 0, 32'(o_presp[0]), 0);
    nxt(); drv(0, 1, 0, 0, 32'h11); smp();
    nxt(); drv(0, 0, 1, 0, 0); smp();
    chk("lit_flush_after", 0, o_pdata[0], 32'h11);

    // async reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      nxt(); drv(0, 1, 0, 0, 32'h20 + 32'(i)); smp();
    end
    nxt(); #2 rst0 = 1'b0; #1;
    chk("lit_arst_cnt", 0, o_cnt[0], 0);
    chk("lit_arst_empty", 0, 32'(o_empty[0]), 1);
    smp();
    nxt(); rst0 = 1'b1; drv(0, 1, 0, 0, 32'h42); smp();
    nxt(); drv(0, 0, 1, 0, 0); smp();
    chk("lit_arst_after", 0, o_pdata[0], 32'h42);

    // push+pop on an empty queue
    nxt(); drv(0, 1, 1, 0, 32'h5A); smp();
`ifdef QUEUE_V2_BYPASS_EN
    chk("lit_byp_data", 0, o_pdata[0], 32'h5A);
    chk("lit_byp_resp", 0, 32'(o_presp[0]), 1);
    nxt(); smp();
    chk("lit_byp_cnt", 0, o_cnt[0], 0);
    chk("lit_byp_empty", 0, 32'(o_empty[0]), 1);
    chk("lit_byp_wresp", 0, 32'(o_wresp[0]), 1);
`else
    chk("lit_nobyp_resp", 0, 32'(o_presp[0]), 0);
    nxt(); drv(0, 0, 1, 0, 0); smp();
    chk("lit_nobyp_cnt", 0, o_cnt[0], 1);
    chk("lit_nobyp_data", 0, o_pdata[0], 32'h5A);
`endif
    nxt(); smp();
    nxt();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
